// File: rtl/host_loader_if.sv
// Byte-stream and core debug-port signals of the host loader.
interface host_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [1:0]  cpu_cmd;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;

   modport master (
      output rx_data, rx_valid, tx_ready, cpu_rdata,
      input  rx_ready, tx_data, tx_valid,
      input  cpu_cmd, cpu_addr, cpu_wdata
   );

   modport slave (
      input  rx_data, rx_valid, tx_ready, cpu_rdata,
      output rx_ready, tx_data, tx_valid,
      output cpu_cmd, cpu_addr, cpu_wdata
   );
endinterface

// File: rtl/host_loader.sv
// Framed byte-command front end driving the core debug/load port.
module host_loader #(
   parameter int unsigned BYTE_TIMEOUT = 65535
) (
   input  logic         clk,
   input  logic         reset,
   host_loader_if.slave bus,
   output logic         cpu_run,
   output logic         busy,
   output logic         err
);
   typedef enum logic [2:0] {
      IDLE, ADDR, DATA, EXEC, RWAIT, TX, RESP
   } state_t;

   state_t      st, st_d;
   logic [1:0]  op;
   logic [7:0]  resp;
   logic [1:0]  cnt;
   logic        ph;
   logic [31:0] tmo;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        rx_rdy, hs, nak, tmo_hit;
   logic [1:0]  cmd;
   logic        txv;
   logic [7:0]  txd;
   logic        is_mem, is_ctl, last_tmo;

   assign hs       = bus.rx_valid && rx_rdy;
   assign is_mem   = bus.rx_data[7:2] == 6'd0;
   assign is_ctl   = bus.rx_data[7:1] == 7'h08;
   assign last_tmo = tmo == BYTE_TIMEOUT - 1;

   always_comb begin
      st_d    = st;
      rx_rdy  = 1'b0;
      cmd     = 2'b00;
      txv     = 1'b0;
      txd     = 8'h00;
      nak     = 1'b0;
      tmo_hit = 1'b0;
      unique case (st)
         IDLE: begin
            rx_rdy = 1'b1;
            if (bus.rx_valid) begin
               unique case (1'b1)
                  is_mem:  st_d = ADDR;
                  is_ctl:  st_d = RESP;
                  default: begin
                     st_d = RESP;
                     nak  = 1'b1;
                  end
               endcase
            end
         end
         ADDR: begin
            rx_rdy = 1'b1;
            if (bus.rx_valid) begin
               if (cnt == 2'd3)
                  st_d = op[0] ? DATA : RWAIT;
            end else if (last_tmo) begin
               st_d    = IDLE;
               tmo_hit = 1'b1;
            end
         end
         DATA: begin
            rx_rdy = 1'b1;
            if (bus.rx_valid) begin
               if (cnt == 2'd3)
                  st_d = EXEC;
            end else if (last_tmo) begin
               st_d    = IDLE;
               tmo_hit = 1'b1;
            end
         end
         EXEC: begin
            // writes are refused while the core is running
            if (cpu_run) nak = 1'b1;
            else         cmd = op;
            st_d = RESP;
         end
         RWAIT: begin
            cmd = op;
            if (ph) st_d = TX;
         end
         TX: begin
            txv = 1'b1;
            txd = rdata_q[{cnt, 3'b000} +: 8];
            if (bus.tx_ready && cnt == 2'd3)
               st_d = IDLE;
         end
         RESP: begin
            txv = 1'b1;
            txd = resp;
            if (bus.tx_ready) st_d = IDLE;
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         st      <= IDLE;
         op      <= 2'b00;
         resp    <= 8'h00;
         cnt     <= 2'd0;
         ph      <= 1'b0;
         tmo     <= 32'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         cpu_run <= 1'b0;
         err     <= 1'b0;
      end else begin
         st  <= st_d;
         err <= nak | tmo_hit;
         unique case (st)
            IDLE: if (hs) begin
               op   <= bus.rx_data[1:0];
               cnt  <= 2'd0;
               tmo  <= 32'd0;
               ph   <= 1'b0;
               resp <= nak ? 8'hEE : 8'hA5;
               if (is_ctl) cpu_run <= ~bus.rx_data[0];
            end
            ADDR: if (hs) begin
               addr_q[{cnt, 3'b000} +: 8] <= bus.rx_data;
               cnt <= cnt + 2'd1;
               tmo <= 32'd0;
            end else begin
               tmo <= tmo + 32'd1;
            end
            DATA: if (hs) begin
               wdata_q[{cnt, 3'b000} +: 8] <= bus.rx_data;
               cnt <= cnt + 2'd1;
               tmo <= 32'd0;
            end else begin
               tmo <= tmo + 32'd1;
            end
            EXEC: resp <= cpu_run ? 8'hEE : 8'hA5;
            RWAIT: begin
               // second cycle covers the memory read latency
               ph <= ~ph;
               if (ph) begin
                  rdata_q <= bus.cpu_rdata;
                  cnt     <= 2'd0;
               end
            end
            TX: if (bus.tx_ready) cnt <= cnt + 2'd1;
            default: ;
         endcase
      end
   end

   assign bus.rx_ready  = rx_rdy & reset;
   assign bus.tx_valid  = txv;
   assign bus.tx_data   = txd;
   assign bus.cpu_cmd   = cmd;
   assign bus.cpu_addr  = addr_q;
   assign bus.cpu_wdata = wdata_q;
   assign busy          = st != IDLE;
endmodule

// File: doc/host_loader.md
# host_loader

Byte-stream command front end for the CPU core's external debug/load port. It takes framed commands from an upstream byte source (UART receiver), drives the core's `cmd` / `addr_in` / `data_in` inputs, and samples the core's `data_out`. Read data and acknowledgements return on a byte-wide transmit stream. It also owns the run/halt control, and so holds the core idle while instruction and data memories are loaded.

## Interface
- `BYTE_TIMEOUT`, default 65535: idle cycles allowed between bytes of a partial frame before the frame is discarded.
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-low reset.
- `rx_data` in 8: incoming command byte.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: block accepts a byte; handshake completes when `rx_valid && rx_ready`.
- `tx_data` out 8: response byte.
- `tx_valid` out 1: `tx_data` valid; held with stable data until accepted.
- `tx_ready` in 1: downstream accepts the response byte.
- `cpu_cmd` out 2: drives core `cmd`.
  - 00 = register read / idle
  - 01 = imem write
  - 10 = dmem read
  - 11 = dmem write
- `cpu_addr` out 32: drives core `addr_in`.
- `cpu_wdata` out 32: drives core `data_in`.
- `cpu_rdata` in 32: core `data_out`.
- `cpu_run` out 1: 1 = core released to execute; 0 = core held.
- `busy` out 1: state != IDLE.
- `err` out 1: one-cycle pulse on NAK or timeout.

## Operation
- **Frame format:** opcode byte, then 4 address bytes (LSB first), then for writes 4 data bytes (LSB first).
- **Opcodes:**
  - 0x00: reg read (5-byte frame).
  - 0x01: imem write (9 bytes).
  - 0x02: dmem read (5 bytes).
  - 0x03: dmem write (9 bytes).
  - 0x10: run (1 byte).
  - 0x11: halt (1 byte).
  - Any other opcode: NAK.
- **States:** IDLE, ADDR, DATA, EXEC, RWAIT, TX, RESP.
- **IDLE:** `rx_ready`=1.
  - Opcodes 0x00–0x03 -> ADDR, with byte count 0.
  - 0x10 sets `cpu_run`=1 -> RESP(0xA5).
  - 0x11 sets `cpu_run`=0 -> RESP(0xA5).
  - Unknown opcode -> RESP(0xEE) and pulse `err`.
- **ADDR / DATA:** `rx_ready`=1. Each accepted byte shifts into `cpu_addr` / `cpu_wdata` at byte lane = count.
  - After the 4th address byte: reads -> RWAIT; writes -> DATA.
  - After the 4th data byte -> EXEC.
- **EXEC:** `cpu_cmd` = opcode[1:0] for exactly one cycle, then 00 -> RESP(0xA5).
  - If `cpu_run`=1, no write is issued (`cpu_cmd` stays 00), `err` pulses, and the state goes to RESP(0xEE).
- **RWAIT:** `cpu_cmd` = opcode[1:0] for 2 cycles. `cpu_rdata` is captured on the 2nd cycle (covers the 1-cycle BRAM read latency), then `cpu_cmd` returns to 00 -> TX. Reads are allowed while running.
- **TX:** sends the 4 captured bytes LSB first, advancing on each `tx_valid && tx_ready` -> IDLE.
- **RESP:** sends 1 byte -> IDLE when accepted.
- `rx_ready`=0 in EXEC, RWAIT, TX and RESP. Bytes presented then are not consumed (backpressure, no loss).
- **Timeout:** in ADDR or DATA, a counter increments each cycle without an rx handshake and clears on each handshake. When it reaches `BYTE_TIMEOUT`: go to IDLE, pulse `err`, send no response, issue no `cpu_cmd`.
- `cpu_addr` / `cpu_wdata` hold their last values outside a frame.

## Timing
- **Reset values** (while `reset`=0): state IDLE, `cpu_cmd`=00, `cpu_addr`=0, `cpu_wdata`=0, `cpu_run`=0, `tx_valid`=0, `tx_data`=0, `rx_ready`=0, `busy`=0, `err`=0, counters 0.
- `reset` asserted mid-frame or mid-TX aborts the operation; outputs reach reset values at the next edge.
- **Write latency:** the 9th byte is accepted at edge N. `cpu_cmd`=01/11 is valid for cycle N+1, and the memory write occurs at edge N+2. `tx_valid`=1 with 0xA5 from cycle N+2.
- **Read latency:** the 5th byte is accepted at edge N. `cpu_cmd` is driven for cycles N+1 and N+2, and `cpu_rdata` is sampled at edge N+3. `tx_valid` is asserted from N+3 with byte 0.
- `tx_data` must not change while `tx_valid`=1 and `tx_ready`=0.
- Back-to-back frames: a new opcode can be accepted in the cycle immediately after the final response byte is accepted.

## Test plan
- **Write imem:** send 01, 00 00 00 00, 13 00 00 00 while halted -> `cpu_cmd`=01 for exactly 1 cycle with `cpu_addr`=0x0, `cpu_wdata`=0x00000013; `tx` returns 0xA5.
- **Dmem round trip:** 03, 08 00 00 00, EF BE AD DE, then 02, 08 00 00 00 -> tx bytes EF BE AD DE.
- **Run guard:** 10 -> 0xA5 and `cpu_run`=1. Then 03 + 8 bytes -> `cpu_cmd` never 11, `err` pulses, `tx` 0xEE. Then 11 -> `cpu_run`=0.
- **Unknown opcode:** 0x55 -> 0xEE with a 1-cycle `err`; the next valid frame completes normally.
- **Timeout and backpressure:**
  - `BYTE_TIMEOUT`=16: send 01, 04 then stall 16 cycles -> IDLE, `err`, no tx.
  - During TX hold `tx_ready`=0 for 10 cycles -> `tx_data` stable and `rx_ready`=0.
- **Reset mid-read:** pull `reset` low during RWAIT -> `cpu_cmd`=00, `tx_valid`=0, `cpu_run`=0 next edge.
